z16_instr_encoder: RTL

//  Encodes Z16 instruction fields (opcode, rd, rs1, rs2, imm) into 16-bit instruction words,
//  the inverse of instruction decode. Writes the words to instruction memory at consecutive

---
 rtl/z16_instr_encoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/z16_instr_encoder.sv
// Z16 instruction encoder: packs opcode/register/immediate fields into 16-bit words
// and streams them into instruction memory at consecutive addresses, halting on bad fields.
module z16_instr_encoder #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic              i_finish,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [3:0]        i_opcode,
   input  logic [3:0]        i_rd_addr,
   input  logic [3:0]        i_rs1_addr,
   input  logic [3:0]        i_rs2_addr,
   input  logic [15:0]       i_imm,
   output logic              o_mem_wen,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [15:0]       o_mem_wdata,
   input  logic              i_mem_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic [1:0]        o_err_code,
   output logic [ADDR_W:0]   o_word_count
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_IMM  = 2'd1;
   localparam logic [1:0] ERR_REG  = 2'd2;
   localparam logic [1:0] ERR_OP9  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_DRAIN = 3'd2,
      S_DONE  = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   state_t              r_state;
   logic                r_wen;
   logic [ADDR_W-1:0]   r_addr;
   logic [15:0]         r_wdata;
   logic [CNT_W-1:0]    r_count;
   logic [1:0]          r_err_code;
   logic                r_last_pend;

   logic [15:0]         w_enc;
   logic [1:0]          w_err_code;
   logic                w_is_op9;
   logic                w_is_imm4;
   logic                w_is_imm8;
   logic                w_is_ef;
   logic                w_imm4_ok;
   logic                w_imm8_ok;
   logic                w_wr_done;
   logic                w_accept;
   logic [ADDR_W-1:0]   w_acc_addr;
   logic                w_acc_last;

   // Opcode classes and signed-immediate range checks (upper bits must be pure sign).
   assign w_is_op9  = (i_opcode == 4'h9);
   assign w_is_imm4 = (i_opcode >= 4'hA) && (i_opcode <= 4'hD);
   assign w_is_ef   = (i_opcode == 4'hE) || (i_opcode == 4'hF);
   assign w_is_imm8 = w_is_op9 || w_is_ef;
   assign w_imm4_ok = (&i_imm[15:3]) || ~(|i_imm[15:3]);
   assign w_imm8_ok = (&i_imm[15:7]) || ~(|i_imm[15:7]);

   always_comb begin
      w_enc = {i_rs2_addr, i_rs1_addr, i_rd_addr, i_opcode};
      case (i_opcode)
         4'h9:              w_enc = {i_imm[7:0], i_rd_addr, i_opcode};
         4'hA, 4'hC, 4'hD:  w_enc = {i_imm[3:0], i_rs1_addr, i_rd_addr, i_opcode};
         4'hB:              w_enc = {i_rs2_addr, i_rs1_addr, i_imm[3:0], i_opcode};
         4'hE, 4'hF:        w_enc = {i_imm[7:0], i_rs2_addr[1:0], i_rs1_addr[1:0], i_opcode};
         default:           w_enc = {i_rs2_addr, i_rs1_addr, i_rd_addr, i_opcode};
      endcase
   end

   // First failing check wins: register range, then op9 aliasing, then immediate range.
   always_comb begin
      w_err_code = ERR_NONE;
      if (w_is_ef && ((i_rs1_addr[3:2] != 2'b00) || (i_rs2_addr[3:2] != 2'b00)))
         w_err_code = ERR_REG;
      else if (w_is_op9 && (i_rs1_addr != i_rd_addr))
         w_err_code = ERR_OP9;
      else if ((w_is_imm4 && !w_imm4_ok) || (w_is_imm8 && !w_imm8_ok))
         w_err_code = ERR_IMM;
   end

   assign o_ready   = (r_state == S_RUN) && !i_finish && (!r_wen || i_mem_ready) && !r_last_pend;
   assign w_accept  = i_valid && o_ready;
   assign w_wr_done = r_wen && i_mem_ready;

   // Address an accepted word lands on: a pending word vacates its slot in the same cycle.
   assign w_acc_addr = r_wen ? (r_addr + ADDR_W'(1)) : r_addr;
   assign w_acc_last = &w_acc_addr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_wen       <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_count     <= '0;
         r_err_code  <= ERR_NONE;
         r_last_pend <= 1'b0;
      end else begin
         if (w_wr_done) begin
            r_wen   <= 1'b0;
            r_addr  <= r_addr + ADDR_W'(1);
            r_count <= r_count + CNT_W'(1);
         end
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (i_start) begin
                  r_state     <= S_RUN;
                  r_addr      <= i_base_addr;
                  r_count     <= '0;
                  r_err_code  <= ERR_NONE;
                  r_wen       <= 1'b0;
                  r_last_pend <= 1'b0;
               end
            end
            S_RUN: begin
               if (w_wr_done && r_last_pend) begin
                  r_state     <= S_DONE;
                  r_last_pend <= 1'b0;
               end else if (i_finish) begin
                  r_state <= S_DRAIN;
               end else if (w_accept) begin
                  if (w_err_code != ERR_NONE) begin
                     r_state    <= S_ERROR;
                     r_err_code <= w_err_code;
                  end else begin
                     r_wen   <= 1'b1;
                     r_wdata <= w_enc;
                     if (w_acc_last)
                        r_last_pend <= 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (!r_wen || i_mem_ready) begin
                  r_state     <= S_DONE;
                  r_last_pend <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_mem_wen    = r_wen;
   assign o_mem_addr   = r_addr;
   assign o_mem_wdata  = r_wdata;
   assign o_word_count = r_count;
   assign o_err_code   = r_err_code;
   assign o_busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign o_done       = (r_state == S_DONE);
   assign o_err        = (r_state == S_ERROR);

endmodule
